// File: rtl/tl_arb_mux_if.sv
// Channel bundle for tl_arb_mux: N source-side ports merged onto one sink-side port.
// The slave modport is the arbiter's view. The master modport is the view of the surrounding logic.
interface tl_arb_mux_if #(
  parameter int N      = 4,
  parameter int DATA_W = 64,
  parameter int SEL_W  = 2
);
  logic [N-1:0]        valid_i;
  logic [N-1:0]        ready_o;
  logic [N*DATA_W-1:0] data_i;
  logic [N-1:0]        last_i;
  logic                valid_o;
  logic                ready_i;
  logic [DATA_W-1:0]   data_o;
  logic                last_o;
  logic [SEL_W-1:0]    sel_o;

  modport slave (
    input  valid_i, data_i, last_i, ready_i,
    output ready_o, valid_o, data_o, last_o, sel_o
  );

  modport master (
    output valid_i, data_i, last_i, ready_i,
    input  ready_o, valid_o, data_o, last_o, sel_o
  );
endinterface

// File: rtl/tl_arb_mux.sv
// N-to-1 round-robin arbitrating mux for one TileLink channel.
// The grant is held across multi-beat messages and across stalled beats. The path is zero-latency.
module tl_arb_mux #(
  parameter int N      = 4,
  parameter int DATA_W = 64,
  parameter int SEL_W  = 2
) (
  input  logic           clk,
  input  logic           rst,
  tl_arb_mux_if.slave    bus
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t           state, state_n;
  logic [SEL_W-1:0] ptr, ptr_n;
  logic [SEL_W-1:0] lock_idx, lock_n;
  logic [SEL_W-1:0] grant;
  logic             found;
  logic             valid;
  int unsigned      idx;

  // Search proceeds from ptr with a modulo-N wrap, so indices >= N are never produced.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    if (!rst) begin
      if (state == LOCKED) begin
        grant = lock_idx;
      end else begin
        for (int unsigned k = 0; k < N; k++) begin
          idx = int'(ptr) + k;
          if (idx >= N) idx = idx - N;
          if (!found && bus.valid_i[idx]) begin
            grant = SEL_W'(idx);
            found = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    valid       = !rst && bus.valid_i[grant];
    bus.valid_o = valid;
    bus.data_o  = bus.data_i[int'(grant)*DATA_W +: DATA_W];
    bus.last_o  = bus.last_i[grant];
    bus.sel_o   = grant;
    bus.ready_o = '0;
    if (!rst && bus.ready_i) bus.ready_o[grant] = 1'b1;
  end

  // Any presented beat that does not finish a message pins the grant, whether it is stalled or mid-burst.
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    lock_n  = lock_idx;
    if (valid) begin
      if (bus.ready_i && bus.last_o) begin
        state_n = IDLE;
        ptr_n   = (grant == SEL_W'(N-1)) ? '0 : grant + SEL_W'(1);
      end else begin
        state_n = LOCKED;
        lock_n  = grant;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      lock_idx <= '0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      lock_idx <= lock_n;
    end
  end

endmodule

// File: tb/tb_tl_arb_mux.sv
// Self-checking bench for tl_arb_mux: an N=4 and an N=3 instance against a message-level reference model.
// The bench drives directed scenarios with literal expectations, followed by a long randomized run.
module tb_tl_arb_mux;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tl_arb_mux_if #(.N(4), .DATA_W(64), .SEL_W(2)) b4 ();
  tl_arb_mux_if #(.N(3), .DATA_W(16), .SEL_W(2)) b3 ();

  tl_arb_mux #(.N(4), .DATA_W(64), .SEL_W(2)) u_dut4 (.clk(clk), .rst(rst), .bus(b4));
  tl_arb_mux #(.N(3), .DATA_W(16), .SEL_W(2)) u_dut3 (.clk(clk), .rst(rst), .bus(b3));

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // The reference state is the rotation pointer plus the port owning an open message. A value of -1 means no port owns one.
  int m_ptr4 = 0, m_lock4 = -1, n_ptr4 = 0, n_lock4 = -1;
  int m_ptr3 = 0, m_lock3 = -1, n_ptr3 = 0, n_lock3 = -1;

  function automatic int pick(input int n, input int ptr, input int lock, input logic [3:0] v);
    if (lock >= 0) return lock;
    for (int k = 0; k < n; k++)
      if (v[(ptr + k) % n]) return (ptr + k) % n;
    return 0;
  endfunction

  always @(negedge clk) begin
    int g;
    logic ev;
    logic [3:0] v;
    // Checks for the N=4 instance
    v  = b4.valid_i;
    g  = rst ? 0 : pick(4, m_ptr4, m_lock4, v);
    ev = !rst && v[g];
    chk("valid4", 64'(b4.valid_o), 64'(ev));
    chk("ready4", 64'(b4.ready_o), (rst || !b4.ready_i) ? 64'd0 : (64'd1 << g));
    chk("sel4",   64'(b4.sel_o),   64'(g));
    chk("last4",  64'(b4.last_o),  64'(b4.last_i[g]));
    chk("data4",  b4.data_o,       b4.data_i[g*64 +: 64]);
    n_ptr4 = m_ptr4; n_lock4 = m_lock4;
    if (rst) begin
      n_ptr4 = 0; n_lock4 = -1;
    end else if (ev) begin
      if (b4.ready_i && b4.last_i[g]) begin n_lock4 = -1; n_ptr4 = (g + 1) % 4; end
      else n_lock4 = g;
    end
    // Checks for the N=3 instance
    v  = {1'b0, b3.valid_i};
    g  = rst ? 0 : pick(3, m_ptr3, m_lock3, v);
    ev = !rst && v[g];
    chk("valid3", 64'(b3.valid_o), 64'(ev));
    chk("ready3", 64'(b3.ready_o), (rst || !b3.ready_i) ? 64'd0 : (64'd1 << g));
    chk("sel3",   64'(b3.sel_o),   64'(g));
    chk("last3",  64'(b3.last_o),  64'(b3.last_i[g]));
    chk("data3",  64'(b3.data_o),  64'(b3.data_i[g*16 +: 16]));
    n_ptr3 = m_ptr3; n_lock3 = m_lock3;
    if (rst) begin
      n_ptr3 = 0; n_lock3 = -1;
    end else if (ev) begin
      if (b3.ready_i && b3.last_i[g]) begin n_lock3 = -1; n_ptr3 = (g + 1) % 3; end
      else n_lock3 = g;
    end
  end

  always @(posedge clk) begin
    m_ptr4 = n_ptr4; m_lock4 = n_lock4;
    m_ptr3 = n_ptr3; m_lock3 = n_lock3;
  end

  // Drives both instances with one pattern. The N=3 instance sees the low three ports and the low 16 bits of each payload.
  task automatic drive(input logic r, input logic [3:0] v, input logic [3:0] l, input logic rdy,
                       input logic [63:0] d0, input logic [63:0] d1, input logic [63:0] d2, input logic [63:0] d3);
    @(posedge clk);
    #1;
    rst        = r;
    b4.valid_i = v;
    b4.last_i  = l;
    b4.ready_i = rdy;
    b4.data_i  = {d3, d2, d1, d0};
    b3.valid_i = v[2:0];
    b3.last_i  = l[2:0];
    b3.ready_i = rdy;
    b3.data_i  = {d2[15:0], d1[15:0], d0[15:0]};
    #1;
  endtask

  localparam logic [63:0] D0 = 64'h0000_0000_0000_A000;
  localparam logic [63:0] D1 = 64'h1111_1111_1111_B111;
  localparam logic [63:0] D3 = 64'h3333_3333_3333_D333;

  initial begin
    logic [63:0] rd [4];
    b4.valid_i = '0; b4.last_i = '0; b4.ready_i = 1'b0; b4.data_i = '0;
    b3.valid_i = '0; b3.last_i = '0; b3.ready_i = 1'b0; b3.data_i = '0;

    // Reset with every port requesting
    drive(1'b1, 4'b1111, 4'b1111, 1'b1, D0, D1, 64'h2, D3);
    chk("rst_valid4", 64'(b4.valid_o), 64'd0);
    chk("rst_ready4", 64'(b4.ready_o), 64'd0);
    chk("rst_ready3", 64'(b3.ready_o), 64'd0);

    // Round-robin of single-beat messages: N=4 gives 0,1,2,3,... and N=3 gives 0,1,2,0,...
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 4'b1111, 4'b1111, 1'b1, D0, D1, 64'h2, D3);
      chk("rr_sel4",   64'(b4.sel_o),   64'(i % 4));
      chk("rr_ready4", 64'(b4.ready_o), 64'd1 << (i % 4));
      chk("rr_sel3",   64'(b3.sel_o),   64'(i % 3));
    end

    // Advance the pointer to port 2, then run a 4-beat burst from port 2 with ports 0 and 1 contending
    drive(1'b0, 4'b0011, 4'b1111, 1'b1, D0, D1, 64'h2, D3);
    drive(1'b0, 4'b0011, 4'b1111, 1'b1, D0, D1, 64'h2, D3);
    for (int b = 0; b < 4; b++) begin
      rd[b] = 64'hC0DE_0000_0000_0000 | 64'(b);
      drive(1'b0, 4'b0111, (b == 3) ? 4'b1111 : 4'b1011, 1'b1, D0, D1, rd[b], D3);
      chk("burst_sel",  64'(b4.sel_o),  64'd2);
      chk("burst_data", b4.data_o,      rd[b]);
    end
    drive(1'b0, 4'b0011, 4'b1111, 1'b1, D0, D1, 64'h2, D3);
    chk("post_burst_sel", 64'(b4.sel_o), 64'd0);

    // A stalled beat from port 1 keeps the grant after port 0 starts requesting
    for (int c = 0; c < 5; c++) begin
      drive(1'b0, (c < 3) ? 4'b0010 : 4'b0011, 4'b1111, (c == 4), D0, D1, 64'h2, D3);
      chk("stall_sel",  64'(b4.sel_o), 64'd1);
      chk("stall_data", b4.data_o,     D1);
      chk("stall_ready", 64'(b4.ready_o), (c == 4) ? 64'b0010 : 64'd0);
    end

    // A gap inside a port-3 burst blocks port 0
    drive(1'b0, 4'b1000, 4'b0000, 1'b1, D0, D1, 64'h2, D3);
    chk("gap_sel", 64'(b4.sel_o), 64'd3);
    for (int c = 0; c < 2; c++) begin
      drive(1'b0, 4'b0001, 4'b1111, 1'b1, D0, D1, 64'h2, D3);
      chk("gap_valid", 64'(b4.valid_o), 64'd0);
      chk("gap_ready", 64'(b4.ready_o), 64'b1000);
    end
    drive(1'b0, 4'b1001, 4'b1111, 1'b1, D0, D1, 64'h2, 64'hBEA7_0002);
    chk("gap_resume_sel",  64'(b4.sel_o), 64'd3);
    chk("gap_resume_data", b4.data_o,     64'hBEA7_0002);

    // Reset during a locked burst from port 1
    drive(1'b0, 4'b0010, 4'b0000, 1'b1, D0, D1, 64'h2, D3);
    chk("lock1_sel4", 64'(b4.sel_o), 64'd1);
    chk("lock1_sel3", 64'(b3.sel_o), 64'd1);
    drive(1'b1, 4'b0011, 4'b0000, 1'b1, D0, D1, 64'h2, D3);
    chk("midrst_valid3", 64'(b3.valid_o), 64'd0);
    drive(1'b0, 4'b0011, 4'b1111, 1'b1, D0, D1, 64'h2, D3);
    chk("postrst_sel4", 64'(b4.sel_o), 64'd0);
    chk("postrst_sel3", 64'(b3.sel_o), 64'd0);

    // Randomized traffic, checked against the model every cycle
    for (int c = 0; c < 3000; c++) begin
      drive(($urandom_range(0, 199) == 0),
            4'($urandom), 4'($urandom | $urandom), ($urandom_range(0, 3) != 0),
            {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
    end
    drive(1'b0, 4'b0000, 4'b1111, 1'b1, D0, D1, 64'h2, D3);
    @(negedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tl_arb_mux.md
Name: tl_arb_mux

Overview:
N-to-1 arbitrating multiplexer for one TileLink channel. It is the converging counterpart of the crossbar demux: it merges N source ports onto a single sink port. Grant is round-robin, and it is locked for the full length of a multi-beat message and while a presented beat is stalled, so that output valid and data stay stable. It sits on the sink side of each crossbar output (for example, A channel into a slave, or D channel into a master).

Parameters:
N, 4, number of input ports (≥2; need not be a power of two)
DATA_W, 64, width of the packed channel payload per port
SEL_W, 2, index width; 2^SEL_W ≥ N required

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
valid_i  input  N  per-port beat valid
ready_o  output  N  per-port beat accepted
data_i  input  N*DATA_W  port i payload at [i*DATA_W +: DATA_W]
last_i  input  N  port i beat is final beat of its message (tie 1 for single-beat)
valid_o  output  1  merged beat valid
ready_i  input  1  sink ready
data_o  output  DATA_W  payload of granted port
last_o  output  1  last_i of granted port
sel_o  output  SEL_W  index of granted port (for source tagging / response routing)

Behaviour:
- Handshake: beat transfers on a cycle where valid and ready are both high. Outputs are combinational from inputs plus registered state; there is no added latency (0-cycle pass-through).
- State: state ∈ {IDLE, LOCKED}, ptr (SEL_W, priority pointer), lock_idx (SEL_W).
- Reset (async assert): state=IDLE, ptr=0, lock_idx=0.
- While rst is high: valid_o=0, ready_o=0. data_o, last_o and sel_o follow grant=0.
- Grant, IDLE: first i with valid_i[i]=1, searching ptr, ptr+1, …, N-1, 0, …, ptr-1. If there are no requests, grant=0 and valid_o=0.
- Grant, LOCKED: grant=lock_idx, regardless of other requests.
- Outputs:
  - valid_o = valid_i[grant]
  - data_o = data_i[grant]
  - last_o = last_i[grant]
  - sel_o = grant
  - ready_o[i] = ready_i && (i==grant) && !rst
  - All ungranted ports see ready_o=0.
- Transitions (evaluated each clock edge):
  - valid_o && ready_i && last_o: state→IDLE; ptr←(grant==N-1)?0:grant+1.
  - valid_o && ready_i && !last_o: state→LOCKED; lock_idx←grant (mid-message lock).
  - valid_o && !ready_i: state→LOCKED; lock_idx←grant (stall lock: grant cannot switch while a beat is presented).
  - !valid_o: state and ptr unchanged.
- LOCKED with valid_i[lock_idx]=0 (gap between beats): valid_o=0; stay LOCKED. Other ports remain blocked.
- Single-beat messages (last=1) from multiple requesters rotate fairly: each requester is served at most once per N grants.
- ptr wraps N-1→0 for non-power-of-two N. Indices ≥N never granted.
- Reset mid-message: lock dropped, ptr=0. The upstream is expected to be reset together with this block.
- No internal storage of payload; throughput is one beat per cycle when ready_i=1.

Test Plan:
- Reset: rst=1 with all valid_i=1 → valid_o=0, ready_o=0000. After release with ready_i=1 → port 0 granted first, sel_o=0.
- Round-robin: N=4, valid_i=1111, last_i=1111, ready_i=1 for 8 cycles → sel_o sequence 0,1,2,3,0,1,2,3; exactly one ready_o bit high each cycle.
- Burst lock: port 2 sends 4 beats (last on 4th) while port 0 and port 1 are continuously valid → sel_o=2 for all 4 beats, data_o matches port 2 beats in order; the next grant is port 3 if requesting, else port 0.
- Stall stability: port 1 alone valid, ready_i=0 for 3 cycles, then port 0 asserts valid → sel_o stays 1 and data_o is unchanged until ready_i=1 accepts the beat.
- Gap in burst: port 3 sends beat 1 (last=0), drops valid_i for 2 cycles while port 0 requests → valid_o=0, ready_o[0]=0; port 3 resumes → its beat 2 is forwarded.
- Non-power-of-two and reset mid-burst: N=3, SEL_W=2, all requesting → sel_o sequence 0,1,2,0. Assert rst during a locked burst on port 1 → after release, port 0 is granted.
